pwm_deadtime: RTL and testbench
===============================

# pwm_deadtime

Complementary-output stage placed directly downstream of the `pwmN` generator. Consumes its single-ended `pwm` signal and drives a high-side/low-side gate pair (`out_h`, `out_l`). A programmable dead time, in clock cycles, guarantees both outputs are never high together. Includes an enable-driven safe state and abort handling for pulses shorter than the dead time.

## Interface
- `N`, default 8, width of the dead-time count.
- `clk`  in  1  system clock, shared with `pwmN`.
- `clr`  in  1  reset, synchronous, active-high.
- `en`  in  1  output enable; 0 forces both outputs low.
- `pwm_in`  in  1  PWM from the upstream generator; may be combinational.
- `dead`  in  N  dead time in cycles; 0 means no dead time.
- `out_h`  out  1  high-side drive, registered.
- `out_l`  out  1  low-side drive, registered.
- `in_dead`  out  1  high while the FSM is in a dead state, registered.

## Operation
- `pwm_in` is registered once into `pwm_q`. The FSM acts only on `pwm_q`.
- States:
  - OFF: `out_h`=0, `out_l`=0.
  - H_ON: `out_h`=1, `out_l`=0.
  - L_ON: `out_h`=0, `out_l`=1.
  - DT_H: both 0, waiting to enter H_ON.
  - DT_L: both 0, waiting to enter L_ON.
- Down-counter `cnt` is N bits wide.
- Transitions, evaluated at each `clk` edge with priority top-down:
  - `clr`=1 → OFF; `cnt`=0; `pwm_q`=0.
  - `en`=0 → OFF, from any state.
  - OFF with `en`=1 → DT_H if `pwm_q`=1, else DT_L. `cnt` <= `dead`-1. If `dead`=0, go straight to H_ON or L_ON.
  - L_ON with `pwm_q`=1 → DT_H, `cnt` <= `dead`-1. If `dead`=0 → H_ON directly.
  - H_ON with `pwm_q`=0 → DT_L, `cnt` <= `dead`-1. If `dead`=0 → L_ON directly.
  - DT_H with `pwm_q`=0 → L_ON (abort; the high side never turned on).
  - DT_H with `cnt`=0 → H_ON; otherwise `cnt` <= `cnt`-1.
  - DT_L: the mirror of DT_H (`pwm_q`=1 → H_ON abort; `cnt`=0 → L_ON).
- `dead` is sampled only when a dead state is entered. Changes mid-count take effect at the next transition.
- Invariant: `out_h` & `out_l` is never 1, in any cycle, including after reset and on `en` toggles.
- `cnt` never wraps. The decrement occurs only when `cnt`≠0.

## Timing
- Reset values: `out_h`=0, `out_l`=0, `in_dead`=0, state OFF.
- Take `pwm_in` as settled before edge k:
  - `pwm_q` updates at edge k.
  - The active output drops at edge k+1.
  - The opposite output rises at edge k+1+`dead`.
- Total latency from `pwm_in` to the rising output is `dead`+2 edges. With `dead`=0, the latency is 2 edges and the outputs swap at the same edge.
- The both-low interval is exactly `dead` cycles when no abort occurs.
- An abort in DT_x restores the previous output at the next edge after `pwm_q` reverts. The both-low interval is then shorter than `dead`.
- A `pwm_in` pulse of width ≤ `dead` cycles produces no pulse on the opposite output.
- `en` falling: both outputs are low at the next edge.
- `en` rising: a full `dead` interval precedes the first asserted output.
- `clr` during a dead count: OFF at the next edge, and the count is discarded.

## Test plan
- Reset then enable:
  - Stimulus: `clr`=1 for 3 cycles, then `en`=1, `pwm_in`=0, `dead`=4.
  - Required: `out_l` rises 4 cycles after OFF exits. `out_h` stays 0. `in_dead`=1 for exactly 4 cycles.
- Steady PWM:
  - Stimulus: `dead`=3, `pwm_in` with period 20 and 10 cycles high.
  - Required: each `out_h` pulse is 7 cycles and each `out_l` pulse is 7 cycles.
  - Required: 3-cycle both-low gaps on each edge; `out_h` rises 5 edges after `pwm_in` rises.
- Short pulse abort:
  - Stimulus: `dead`=5, `pwm_in` high for 2 cycles while in L_ON.
  - Required: `out_h` never asserts. `out_l` low for 2 cycles, then high again.
- Zero dead time:
  - Stimulus: `dead`=0.
  - Required: `out_h` and `out_l` swap on the same edge, 2 edges after `pwm_in` changes, with no overlap cycle.
- Mid-operation events:
  - `en`→0 while in H_ON → both outputs 0 at the next edge.
  - `dead` changed from 2 to 6 during DT_L → the current gap stays 2, and the next gap is 6.
  - `clr` pulsed during DT_H → OFF, both outputs 0.
- Invariant check: random `pwm_in`/`en`/`dead` for 10k cycles → `out_h` & `out_l` is never 1.

Source files
------------

// File: rtl/pwm_deadtime.sv
// Complementary high/low gate driver fed by a single-ended PWM, with programmable dead time,
// enable-driven safe state and abort of pulses shorter than the dead time.
module pwm_deadtime #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         pwm_in,
    input  logic [N-1:0] dead,
    output logic         out_h,
    output logic         out_l,
    output logic         in_dead
);

    typedef enum logic [2:0] {
        StOff,
        StHOn,
        StLOn,
        StDtH,
        StDtL
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic         pwm_q;
    logic         dead_zero;
    logic [N-1:0] dead_m1;

    assign dead_zero = (dead == '0);
    assign dead_m1   = dead - N'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = StOff;
        end else begin
            unique case (state_q)
                StOff: begin
                    if (pwm_q) begin
                        state_d = dead_zero ? StHOn : StDtH;
                    end else begin
                        state_d = dead_zero ? StLOn : StDtL;
                    end
                    cnt_d = dead_zero ? '0 : dead_m1;
                end
                StLOn: begin
                    if (pwm_q) begin
                        state_d = dead_zero ? StHOn : StDtH;
                        cnt_d   = dead_zero ? '0 : dead_m1;
                    end
                end
                StHOn: begin
                    if (!pwm_q) begin
                        state_d = dead_zero ? StLOn : StDtL;
                        cnt_d   = dead_zero ? '0 : dead_m1;
                    end
                end
                // Input reverting before the count expires restores the previous side.
                StDtH: begin
                    if (!pwm_q) begin
                        state_d = StLOn;
                    end else if (cnt_q == '0) begin
                        state_d = StHOn;
                    end else begin
                        cnt_d = cnt_q - N'(1);
                    end
                end
                StDtL: begin
                    if (pwm_q) begin
                        state_d = StHOn;
                    end else if (cnt_q == '0) begin
                        state_d = StLOn;
                    end else begin
                        cnt_d = cnt_q - N'(1);
                    end
                end
                default: state_d = StOff;
            endcase
        end
    end

    // Outputs are flops decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StOff;
            cnt_q   <= '0;
            pwm_q   <= 1'b0;
            out_h   <= 1'b0;
            out_l   <= 1'b0;
            in_dead <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pwm_q   <= pwm_in;
            out_h   <= (state_d == StHOn);
            out_l   <= (state_d == StLOn);
            in_dead <= (state_d == StDtH) || (state_d == StDtL);
        end
    end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboard bench for pwm_deadtime: a behavioural model queues expected outputs per cycle,
// plus directed pulse-width, gap and latency measurements.
module tb_pwm_deadtime;
    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         clr, en, pwm_in;
    logic [N-1:0] dead;
    logic         out_h, out_l, in_dead;

    always #5 clk = ~clk;

    pwm_deadtime #(.N(N)) dut (
        .clk     (clk),
        .clr     (clr),
        .en      (en),
        .pwm_in  (pwm_in),
        .dead    (dead),
        .out_h   (out_h),
        .out_l   (out_l),
        .in_dead (in_dead)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Model: which side is driven, and which side (if any) is pending with cycles left.
    bit m_p = 0, m_h = 0, m_l = 0;
    int m_pend = -1;
    int m_left = 0;
    logic [2:0] exp_q[$];

    task automatic model_drive(input bit side);
        m_h    = side;
        m_l    = !side;
        m_pend = -1;
    endtask

    task automatic model_step(input logic c, input logic e, input logic p, input logic [N-1:0] d);
        bit p_old;
        if (c) begin
            m_p = 0; m_h = 0; m_l = 0; m_pend = -1; m_left = 0;
            return;
        end
        p_old = m_p;
        m_p   = p;
        if (!e) begin
            m_h = 0; m_l = 0; m_pend = -1;
        end else if (m_pend < 0) begin
            if ((!m_h && !m_l) || (m_h != p_old)) begin
                if (d == 0) begin
                    model_drive(p_old);
                end else begin
                    m_h = 0; m_l = 0; m_pend = int'(p_old); m_left = int'(d) - 1;
                end
            end
        end else if (int'(p_old) != m_pend) begin
            model_drive(p_old);
        end else if (m_left == 0) begin
            model_drive(m_pend[0]);
        end else begin
            m_left--;
        end
    endtask

    bit prev_h = 0, prev_l = 0, prev_both = 0;
    bit h_rose, l_rose, h_fell, l_fell, gap_end;
    int h_run = 0, l_run = 0, gap_run = 0;
    int last_h = 0, last_l = 0, last_gap = 0;

    task automatic step(input logic c, input logic e, input logic p, input logic [N-1:0] d);
        logic [2:0] exp;
        bit both;
        clr = c; en = e; pwm_in = p; dead = d;
        model_step(c, e, p, d);
        exp_q.push_back({m_h, m_l, (m_pend >= 0) ? 1'b1 : 1'b0});
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check("out_h", out_h, exp[2]);
        check("out_l", out_l, exp[1]);
        check("in_dead", in_dead, exp[0]);
        check("overlap", out_h & out_l, 0);
        both    = !out_h && !out_l;
        h_rose  = !prev_h && out_h;
        l_rose  = !prev_l && out_l;
        h_fell  = prev_h && !out_h;
        l_fell  = prev_l && !out_l;
        gap_end = prev_both && !both;
        if (h_fell) last_h = h_run;
        if (l_fell) last_l = l_run;
        if (gap_end) last_gap = gap_run;
        h_run   = out_h ? h_run + 1 : 0;
        l_run   = out_l ? l_run + 1 : 0;
        gap_run = both ? gap_run + 1 : 0;
        prev_h = out_h; prev_l = out_l; prev_both = both;
    endtask

    initial begin
        int dz, first_l, lowcnt, nboth, run_left;
        bit hseen, rp, re, rc;

        // Reset then enable with pwm low, dead = 4.
        repeat (3) step(1, 0, 0, 4);
        check("reset_h", out_h, 0);
        check("reset_l", out_l, 0);
        check("reset_dead", in_dead, 0);
        dz = 0; first_l = -1; hseen = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 4);
            dz += int'(in_dead);
            if (first_l < 0 && out_l) first_l = i;
            hseen |= out_h;
        end
        check("en_dead_cycles", dz, 4);
        check("en_l_rise", first_l, 4);
        check("en_h_quiet", hseen, 0);

        // Steady PWM: dead = 3, period 20, 10 high.
        for (int per = 0; per < 3; per++) begin
            for (int i = 0; i < 20; i++) begin
                step(0, 1, (i < 10), 3);
                if (h_rose) check("steady_h_lat", i, 4);
                if (h_fell) check("steady_h_width", last_h, 7);
                if (l_fell && per > 0) check("steady_l_width", last_l, 7);
                if (gap_end) check("steady_gap", last_gap, 3);
            end
        end

        // Short pulse abort: 2-cycle high pulse with dead = 5 while in L_ON.
        lowcnt = 0; hseen = 0;
        for (int i = 0; i < 14; i++) begin
            step(0, 1, (i < 2), 5);
            lowcnt += int'(!out_l);
            hseen |= out_h;
        end
        check("abort_h_quiet", hseen, 0);
        check("abort_l_low", lowcnt, 2);
        check("abort_l_back", out_l, 1);

        // Zero dead time: outputs swap on one edge.
        nboth = 0;
        for (int i = 0; i < 24; i++) begin
            step(0, 1, ((i % 12) < 6), 0);
            if (!out_h && !out_l) nboth++;
            if (h_rose) begin
                check("zero_h_lat", i % 12, 1);
                check("zero_swap_l", l_fell, 1);
            end
            if (l_rose) begin
                check("zero_l_lat", i % 12, 7);
                check("zero_swap_h", h_fell, 1);
            end
        end
        check("zero_no_gap", nboth, 0);

        // en falling while in H_ON.
        for (int k = 0; k < 20 && !out_h; k++) step(0, 1, 1, 2);
        check("enoff_reach_h", out_h, 1);
        step(0, 0, 1, 2);
        check("enoff_h", out_h, 0);
        check("enoff_l", out_l, 0);

        // dead changed 2 -> 6 mid DT_L: current gap stays 2, next is 6.
        for (int k = 0; k < 20 && !out_h; k++) step(0, 1, 1, 2);
        step(0, 1, 0, 2);
        step(0, 1, 0, 2);
        check("dtchg_in_dt_l", in_dead, 1);
        for (int k = 0; k < 20 && !out_l; k++) step(0, 1, 0, 6);
        check("dtchg_gap1", last_gap, 2);
        for (int k = 0; k < 20 && !out_h; k++) step(0, 1, 1, 6);
        check("dtchg_gap2", last_gap, 6);

        // clr during DT_H.
        for (int k = 0; k < 20 && !out_l; k++) step(0, 1, 0, 6);
        step(0, 1, 1, 6);
        step(0, 1, 1, 6);
        check("clr_pre_dead", in_dead, 1);
        step(1, 1, 1, 6);
        check("clr_h", out_h, 0);
        check("clr_l", out_l, 0);
        check("clr_dead", in_dead, 0);
        repeat (4) step(0, 1, 1, 6);

        // Random pwm/en/dead/clr; scoreboard plus overlap check every cycle.
        run_left = 0; rp = 0;
        for (int i = 0; i < 10000; i++) begin
            if (run_left == 0) begin
                rp = 1'($urandom_range(0, 1));
                run_left = $urandom_range(1, 12);
            end
            run_left--;
            re = ($urandom_range(0, 49) != 0);
            rc = ($urandom_range(0, 499) == 0);
            step(rc, re, rp, N'($urandom_range(0, 7)));
        end
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
